// File: rtl/dma_secure_master.sv
// Word-by-word memory-to-memory copier on the openMSP430 DMA slave port.
// Bus requests are withheld whenever the CPU is executing from secure ROM.
//
// state  | meaning
// IDLE   | waiting for start; bus quiet, dma_addr=0
// RD     | read request at src pending
// RDW    | read accepted; capture dma_dout into the data register
// WR     | write request of the data register to dst pending
// FIN    | done pulse, back to IDLE
// ERR    | err pulse (slave error or abort), back to IDLE
module dma_secure_master #(
  parameter logic [15:0] SMEM_BASE = 16'hA000,
  parameter logic [15:0] SMEM_SIZE = 16'h4000,
  parameter int unsigned MAX_LEN_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [15:0]          pc,
  input  logic                 start,
  input  logic                 abort,
  input  logic [15:0]          src_addr,
  input  logic [15:0]          dst_addr,
  input  logic [MAX_LEN_W-1:0] len,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [15:0]          dma_addr,
  output logic                 dma_en,
  output logic [1:0]           dma_we,
  output logic [15:0]          dma_din,
  input  logic                 dma_ready,
  input  logic                 dma_resp,
  input  logic [15:0]          dma_dout
);

  localparam logic [15:0] SMEM_LAST = SMEM_BASE + SMEM_SIZE - 16'd2;
  localparam logic [MAX_LEN_W-1:0] CNT_ONE = {{(MAX_LEN_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RDW,
    S_WR,
    S_FIN,
    S_ERR
  } state_e;

  state_e               state_q, state_d;
  logic [15:0]          src_q, src_d;
  logic [15:0]          dst_q, dst_d;
  logic [15:0]          data_q, data_d;
  logic [15:0]          addr_q, addr_d;
  logic [1:0]           we_q, we_d;
  logic [MAX_LEN_W-1:0] cnt_q, cnt_d;

  logic in_smem;
  logic req;
  logic acc;

  assign in_smem  = (pc >= SMEM_BASE) && (pc <= SMEM_LAST);
  assign req      = (state_q == S_RD) || (state_q == S_WR);
  // Purely combinational so a pc entering secure ROM drops the request in the same cycle.
  assign dma_en   = req && !in_smem && !abort;
  assign acc      = dma_en && dma_ready;

  assign busy     = req || (state_q == S_RDW);
  assign done     = (state_q == S_FIN);
  assign err      = (state_q == S_ERR);
  assign dma_addr = addr_q;
  assign dma_we   = we_q;
  assign dma_din  = data_q;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    data_d  = data_q;
    addr_d  = addr_q;
    we_d    = we_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        addr_d = 16'h0000;
        we_d   = 2'b00;
        if (start) begin
          src_d = {src_addr[15:1], 1'b0};
          dst_d = {dst_addr[15:1], 1'b0};
          cnt_d = len;
          if (len == '0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_RD;
            addr_d  = {src_addr[15:1], 1'b0};
          end
        end
      end

      S_RD: begin
        if (acc && dma_resp) begin
          state_d = S_ERR;
          addr_d  = 16'h0000;
        end else if (acc) begin
          state_d = S_RDW;
        end else if (abort) begin
          state_d = S_ERR;
          addr_d  = 16'h0000;
        end
      end

      S_RDW: begin
        data_d  = dma_dout;
        state_d = S_WR;
        addr_d  = dst_q;
        we_d    = 2'b11;
      end

      S_WR: begin
        if (acc && dma_resp) begin
          state_d = S_ERR;
          addr_d  = 16'h0000;
          we_d    = 2'b00;
        end else if (acc) begin
          src_d = src_q + 16'd2;
          dst_d = dst_q + 16'd2;
          cnt_d = cnt_q - CNT_ONE;
          we_d  = 2'b00;
          if (cnt_q != CNT_ONE) begin
            state_d = S_RD;
            addr_d  = src_q + 16'd2;
          end else begin
            state_d = S_FIN;
            addr_d  = 16'h0000;
          end
        end else if (abort) begin
          state_d = S_ERR;
          addr_d  = 16'h0000;
          we_d    = 2'b00;
        end
      end

      S_FIN, S_ERR: begin
        state_d = S_IDLE;
        addr_d  = 16'h0000;
        we_d    = 2'b00;
      end

      default: begin
        state_d = S_IDLE;
        addr_d  = 16'h0000;
        we_d    = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      src_q   <= 16'h0000;
      dst_q   <= 16'h0000;
      data_q  <= 16'h0000;
      addr_q  <= 16'h0000;
      we_q    <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dma_secure_master.sv
// Bench for dma_secure_master: memory-backed slave, bus/event scoreboard and directed copies.
module tb_dma_secure_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] pc;
  logic        start;
  logic        abort;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] dma_addr;
  logic        dma_en;
  logic [1:0]  dma_we;
  logic [15:0] dma_din;
  logic        dma_ready;
  logic        dma_resp;
  logic [15:0] dma_dout = 16'h0000;
  logic        err_inject;

  typedef struct packed {
    logic [1:0]  we;
    logic [15:0] addr;
    logic [15:0] data;
  } acc_t;

  acc_t        exp_q[$];
  logic [1:0]  ev_q[$];
  logic [15:0] mem [0:32767];
  int          total = 0;
  int          bad = 0;

  dma_secure_master dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pc        (pc),
    .start     (start),
    .abort     (abort),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dma_addr  (dma_addr),
    .dma_en    (dma_en),
    .dma_we    (dma_we),
    .dma_din   (dma_din),
    .dma_ready (dma_ready),
    .dma_resp  (dma_resp),
    .dma_dout  (dma_dout)
  );

  always #5 clk = ~clk;

  // Slave error is injected only on write beats.
  assign dma_resp = err_inject && dma_en && (dma_we == 2'b11);

  always @(posedge clk) begin
    if (dma_en && dma_ready && !dma_resp) begin
      if (dma_we == 2'b11) mem[dma_addr[15:1]] = dma_din;
      else dma_dout <= mem[dma_addr[15:1]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  function automatic logic [15:0] rd(input logic [15:0] a);
    return mem[a[15:1]];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rd(input logic [15:0] a);
    acc_t t;
    t.we = 2'b00; t.addr = a; t.data = 16'h0000;
    exp_q.push_back(t);
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [15:0] d);
    acc_t t;
    t.we = 2'b11; t.addr = a; t.data = d;
    exp_q.push_back(t);
  endtask

  task automatic go(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
    src_addr = s; dst_addr = d; len = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && ev_q.size() == 0 && !busy && !done && !err) break;
      tick();
    end
    check({name, "_complete"}, 32'(i < 200), 32'd1);
    if (i >= 200) begin
      exp_q.delete();
      ev_q.delete();
    end
  endtask

  // Monitor: every accepted bus beat and every done/err pulse is matched against the queues.
  always @(negedge clk) begin : mon
    acc_t       e;
    logic [1:0] ev;
    if (reset_n) begin
      if (dma_en && dma_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_access: got addr %h we %b, want no access", dma_addr, dma_we);
        end else begin
          e = exp_q.pop_front();
          check("bus_addr", 32'(dma_addr), 32'(e.addr));
          check("bus_we", 32'(dma_we), 32'(e.we));
          if (e.we == 2'b11) check("bus_wdata", 32'(dma_din), 32'(e.data));
        end
      end
      if (done || err) begin
        if (ev_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_event: got done=%b err=%b, want none", done, err);
        end else begin
          ev = ev_q.pop_front();
          check("event", 32'({done, err}), 32'(ev));
        end
      end
      if (dma_en && pc >= 16'hA000 && pc <= 16'hDFFE) begin
        total++; bad++;
        $display("FAIL smem_gate: got dma_en=1 at pc %h, want 0", pc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset_n = 1'b0; pc = 16'hF000; start = 1'b0; abort = 1'b0;
    src_addr = 16'h0; dst_addr = 16'h0; len = 16'h0;
    dma_ready = 1'b1; err_inject = 1'b0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
    mem[16'h0200 >> 1] = 16'h1111;
    mem[16'h0202 >> 1] = 16'h2222;
    mem[16'h0204 >> 1] = 16'h3333;
    mem[16'h0300 >> 1] = 16'hAAAA;
    mem[16'h0302 >> 1] = 16'hBBBB;
    mem[16'h0600 >> 1] = 16'h6060;
    mem[16'hFFFE >> 1] = 16'h1234;
    mem[16'h0000 >> 1] = 16'h5678;

    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_en", 32'(dma_en), 32'd0);
    check("rst_addr", 32'(dma_addr), 32'd0);
    check("rst_we", 32'(dma_we), 32'd0);
    check("rst_din", 32'(dma_din), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // basic three-word copy
    push_rd(16'h0200); push_wr(16'h0400, 16'h1111);
    push_rd(16'h0202); push_wr(16'h0402, 16'h2222);
    push_rd(16'h0204); push_wr(16'h0404, 16'h3333);
    ev_q.push_back(2'b10);
    go(16'h0200, 16'h0400, 16'd3);
    check("busy_rise", 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 20) begin tick(); n++; end
    check("done_latency", 32'(n), 32'd9);
    wait_idle("basic");
    check("img_0400", 32'(rd(16'h0400)), 32'h1111);
    check("img_0402", 32'(rd(16'h0402)), 32'h2222);
    check("img_0404", 32'(rd(16'h0404)), 32'h3333);

    // secure holdoff during the second read
    push_rd(16'h0300); push_wr(16'h0500, 16'hAAAA);
    push_rd(16'h0302); push_wr(16'h0502, 16'hBBBB);
    ev_q.push_back(2'b10);
    go(16'h0300, 16'h0500, 16'd2);
    tick(); tick(); tick();
    pc = 16'hA010;
    #1;
    check("holdoff_addr", 32'(dma_addr), 32'h0302);
    for (int i = 0; i < 5; i++) begin
      check("holdoff_en", 32'(dma_en), 32'd0);
      check("holdoff_busy", 32'(busy), 32'd1);
      tick();
    end
    pc = 16'hF000;
    wait_idle("holdoff");
    check("img_0500", 32'(rd(16'h0500)), 32'hAAAA);
    check("img_0502", 32'(rd(16'h0502)), 32'hBBBB);

    // pc boundary values with a pending, unacknowledged read
    dma_ready = 1'b0;
    push_rd(16'h0600); push_wr(16'h0610, 16'h6060);
    ev_q.push_back(2'b10);
    go(16'h0600, 16'h0610, 16'd1);
    pc = 16'h9FFE; #1; check("pc_9ffe_en", 32'(dma_en), 32'd1);
    pc = 16'hE000; #1; check("pc_e000_en", 32'(dma_en), 32'd1);
    pc = 16'hA000; #1; check("pc_a000_en", 32'(dma_en), 32'd0);
    pc = 16'hDFFE; #1; check("pc_dffe_en", 32'(dma_en), 32'd0);
    tick();
    pc = 16'hF000;
    dma_ready = 1'b1;
    wait_idle("boundary");
    check("img_0610", 32'(rd(16'h0610)), 32'h6060);

    // zero length
    ev_q.push_back(2'b10);
    go(16'h0700, 16'h0710, 16'd0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_en", 32'(dma_en), 32'd0);
    check("zero_busy", 32'(busy), 32'd0);
    wait_idle("zero");

    // source address wrap
    push_rd(16'hFFFE); push_wr(16'h0720, 16'h1234);
    push_rd(16'h0000); push_wr(16'h0722, 16'h5678);
    ev_q.push_back(2'b10);
    go(16'hFFFE, 16'h0720, 16'd2);
    wait_idle("wrap");
    check("img_0720", 32'(rd(16'h0720)), 32'h1234);
    check("img_0722", 32'(rd(16'h0722)), 32'h5678);

    // slave error on the first write
    err_inject = 1'b1;
    push_rd(16'h0200); push_wr(16'h0800, 16'h1111);
    ev_q.push_back(2'b01);
    go(16'h0200, 16'h0800, 16'd2);
    wait_idle("resp_err");
    check("err_busy", 32'(busy), 32'd0);
    check("err_en", 32'(dma_en), 32'd0);
    check("err_nowrite", 32'(rd(16'h0800)), 32'h0000);
    err_inject = 1'b0;

    // abort during the second read
    push_rd(16'h0200); push_wr(16'h0900, 16'h1111);
    ev_q.push_back(2'b01);
    go(16'h0200, 16'h0900, 16'd3);
    tick(); tick(); tick();
    abort = 1'b1;
    #1;
    check("abort_en", 32'(dma_en), 32'd0);
    tick();
    check("abort_err", 32'(err), 32'd1);
    abort = 1'b0;
    wait_idle("abort");
    check("img_0900", 32'(rd(16'h0900)), 32'h1111);
    check("img_0902", 32'(rd(16'h0902)), 32'h0000);

    // asynchronous reset while a write is pending
    push_rd(16'h0200);
    go(16'h0200, 16'h0A00, 16'd2);
    tick(); tick();
    check("wr_en_pre_rst", 32'(dma_en), 32'd1);
    check("wr_we_pre_rst", 32'(dma_we), 32'h3);
    reset_n = 1'b0;
    #1;
    check("async_rst_en", 32'(dma_en), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_addr", 32'(dma_addr), 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_addr", 32'(dma_addr), 32'd0);
    check("post_rst_q", 32'(exp_q.size()), 32'd0);
    check("rst_nowrite", 32'(rd(16'h0A00)), 32'h0000);
    push_rd(16'h0204); push_wr(16'h0B00, 16'h3333);
    ev_q.push_back(2'b10);
    go(16'h0204, 16'h0B00, 16'd1);
    wait_idle("post_rst_copy");
    check("img_0b00", 32'(rd(16'h0B00)), 32'h3333);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
